// File: rtl/c7b_mem_arb.sv
// c7b_mem_arb: arbitrates the IFU and LSU onto one word-wide memory port,
// runs one memory transaction at a time, and does the byte-lane work for
// sub-word loads and stores. Misaligned LSU accesses are answered locally
// with lsu_ale and never reach memory.
//
// Handshakes: a requester raises *_req and holds it and its fields until it
// sees a one-cycle *_ack; the arbiter raises mem_req and holds it and every
// mem_* field stable until it samples mem_ack=1 at a rising clock edge.
// mem_ack is ignored whenever mem_req is low.
module c7b_mem_arb #(
  parameter int FAIR_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ack,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req,
  input  logic        lsu_wr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_sign,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ack,
  output logic [31:0] lsu_rdata,
  output logic        lsu_ale,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [3:0] FAIR_MAX_C = 4'(FAIR_MAX);

  state_e      state_q, state_d;
  logic [3:0]  fair_cnt_q, fair_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_sign_q, ld_sign_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic        ifu_ack_q, ifu_ack_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic        lsu_ack_q, lsu_ack_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        lsu_ale_q, lsu_ale_d;

  logic        lsu_misaligned;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        grant_lsu;

  // Fetch addresses are word addresses; the low bits carry no information.
  logic unused_ifu_lsb;
  assign unused_ifu_lsb = ^ifu_addr[1:0];

  // Decode the presented LSU access: alignment check, store strobes and lane replication.
  always_comb begin
    lsu_misaligned = 1'b0;
    st_strb        = 4'b0000;
    st_wdata       = 32'h0;
    case (lsu_size)
      2'd0: begin
        st_strb  = 4'b0001 << lsu_addr[1:0];
        st_wdata = {4{lsu_wdata[7:0]}};
      end
      2'd1: begin
        lsu_misaligned = lsu_addr[0];
        st_strb        = lsu_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata       = {2{lsu_wdata[15:0]}};
      end
      2'd2: begin
        lsu_misaligned = |lsu_addr[1:0];
        st_strb        = 4'b1111;
        st_wdata       = lsu_wdata;
      end
      default: begin
        lsu_misaligned = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    ld_byte = 8'h0;
    ld_half = ld_lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    case (ld_lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    case (ld_size_q)
      2'd0:    ld_data = {{24{ld_sign_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{ld_sign_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // The LSU wins a contested cycle until it has taken FAIR_MAX grants in a row.
  assign grant_lsu = lsu_req && (!ifu_req || (fair_cnt_q != FAIR_MAX_C));

  // Next-state, fairness counter, memory fields and registered responses.
  always_comb begin
    state_d     = state_q;
    fair_cnt_d  = fair_cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = mem_wr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    ld_size_d   = ld_size_q;
    ld_sign_d   = ld_sign_q;
    ld_lane_d   = ld_lane_q;
    ifu_ack_d   = 1'b0;
    ifu_rdata_d = 32'h0;
    lsu_ack_d   = 1'b0;
    lsu_rdata_d = 32'h0;
    lsu_ale_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          if (lsu_misaligned) begin
            // Trapped locally: no memory cycle and no effect on fairness.
            state_d   = DONE;
            lsu_ack_d = 1'b1;
            lsu_ale_d = 1'b1;
          end else begin
            state_d     = BUSY_LS;
            fair_cnt_d  = ifu_req ? (fair_cnt_q + 4'd1) : 4'd0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {lsu_addr[31:2], 2'b00};
            mem_wr_d    = lsu_wr;
            mem_wstrb_d = lsu_wr ? st_strb : 4'b0000;
            mem_wdata_d = lsu_wr ? st_wdata : 32'h0;
            ld_size_d   = lsu_size;
            ld_sign_d   = lsu_sign;
            ld_lane_d   = lsu_addr[1:0];
          end
        end else if (ifu_req) begin
          state_d     = BUSY_IF;
          fair_cnt_d  = 4'd0;
          mem_req_d   = 1'b1;
          mem_addr_d  = {ifu_addr[31:2], 2'b00};
          mem_wr_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_addr_d  = 32'h0;
          mem_wr_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
          ifu_ack_d   = 1'b1;
          ifu_rdata_d = mem_rdata;
        end
      end
      BUSY_LS: begin
        if (mem_ack) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_addr_d  = 32'h0;
          mem_wr_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
          lsu_ack_d   = 1'b1;
          lsu_rdata_d = mem_wr_q ? 32'h0 : ld_data;
        end
      end
      default: begin
        // One dead cycle so the requester can drop or change its request.
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE with every output low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fair_cnt_q  <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wr_q    <= 1'b0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      ld_size_q   <= 2'd0;
      ld_sign_q   <= 1'b0;
      ld_lane_q   <= 2'd0;
      ifu_ack_q   <= 1'b0;
      ifu_rdata_q <= 32'h0;
      lsu_ack_q   <= 1'b0;
      lsu_rdata_q <= 32'h0;
      lsu_ale_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fair_cnt_q  <= fair_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      ld_size_q   <= ld_size_d;
      ld_sign_q   <= ld_sign_d;
      ld_lane_q   <= ld_lane_d;
      ifu_ack_q   <= ifu_ack_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_ack_q   <= lsu_ack_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_ale_q   <= lsu_ale_d;
    end
  end

  assign ifu_ack   = ifu_ack_q;
  assign ifu_rdata = ifu_rdata_q;
  assign lsu_ack   = lsu_ack_q;
  assign lsu_rdata = lsu_rdata_q;
  assign lsu_ale   = lsu_ale_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule
